instr_fetch_decode: RTL
=======================

Name: instr_fetch_decode

Overview:
Upstream neighbour of the PE `controller`.
- On the controller's `IRenable` strobe, captures the controller's `PCout` and fetches one 32-bit instruction word over a read/ack memory handshake.
- Holds the word in an instruction register and splits it into the decoded fields the controller consumes (`op`, `funct3`, `funct7`, `rs1`, `rs2`, `rd`, `imm12`, `immhi`).
- Signals `decodeComplete` when those fields are valid and stable.

Parameters:
- XLEN, 32, instruction/address width (fixed at 32; only checked by assertion).
- FETCH_TIMEOUT, 255, max cycles waiting for `imem_ack` (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- IRenable  in  1  fetch strobe from controller.
- PCin  in  32  fetch address (controller PCout).
- imem_read  out  1  instruction memory read request.
- imem_address  out  32  word address of the fetch.
- imem_data  in  32  instruction word from memory.
- imem_ack  in  1  memory data valid.
- op  out  7  ir[6:0].
- funct3  out  3  ir[14:12].
- funct7  out  7  ir[31:25].
- rs1  out  5  ir[19:15].
- rs2  out  5  ir[24:20].
- rd  out  5  ir[11:7], raw even for S/B types.
- imm12  out  12  type-dependent 12-bit immediate.
- immhi  out  20  type-dependent 20-bit immediate.
- instr_pc  out  32  PC of the decoded instruction.
- decodeComplete  out  1  fields valid.
- illegal  out  1  opcode not in RV32I base set.
- fetch_fault  out  1  misaligned PC or fetch timeout.

Behaviour:
- One clock; reset is synchronous and active-high.
- States: IDLE, FETCH, DECODE, DONE. Reset value: IDLE, with every output and the internal IR at 0.
- IDLE / DONE:
  - If IRenable=1 at an edge: capture PCin into pc_q and clear decodeComplete, illegal and fetch_fault.
  - If PCin[1:0]==0: go to FETCH.
  - If PCin[1:0]!=0: set IR=0 and fetch_fault=1, go to DECODE. No memory read is issued.
- FETCH:
  - imem_read=1 and imem_address=pc_q, decoded from state. Both are 0 in every other state.
  - On the edge where imem_ack=1: IR<=imem_data, go to DECODE.
  - imem_read stays high until ack is sampled.
  - IRenable is ignored in FETCH, including when it coincides with ack.
- DECODE (one cycle):
  - Register all fields from IR, plus instr_pc<=pc_q.
  - Set decodeComplete<=1, go to DONE.
- DONE: fields and decodeComplete are held until the next IRenable or reset.
- Immediate mapping by op:
  - I-type (0010011, 0000011, 1100111, 1110011): imm12=ir[31:20].
  - S-type (0100011): imm12={ir[31:25],ir[11:7]}.
  - B-type (1100011): imm12={ir[31],ir[7],ir[30:25],ir[11:8]}.
  - U-type (0110111, 0010111): immhi=ir[31:12].
  - J-type (1101111): immhi={ir[31],ir[19:12],ir[20],ir[30:21]}.
  - Unused immediate outputs are 0. R-type and FENCE: both immediates are 0.
- illegal=1 if op is not one of {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111}. An all-zero IR is therefore illegal.
- Latency with a zero-wait memory (ack in the first FETCH cycle):
  - IRenable sampled at edge E0, ack at E1, decodeComplete high after E2.
  - Each memory wait cycle adds one cycle.
- Reset mid-operation: at the next edge, return to IDLE with all outputs 0. imem_read is low from that edge on. An in-flight ack is discarded.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8-bit wait counter clears on entry to FETCH and increments on each FETCH cycle without ack.
  - When the counter reaches FETCH_TIMEOUT: IR<=0, fetch_fault<=1, go to DECODE, so decodeComplete=1 and illegal=1.
  - An ack on the timeout cycle wins: normal fetch, no fault.
- Undefined:
  - No counter; FETCH waits indefinitely.
  - fetch_fault is driven only by misalignment.

Test Plan:
- Zero-wait fetch: reset, PCin=0, IRenable pulse, imem_data=0x00610113 with ack in the same cycle → op=0010011, rd=2, rs1=2, funct3=000, imm12=0x006, illegal=0, decodeComplete high 2 edges after the IRenable edge.
- Wait states: PCin=1 pulse then PCin=4, imem_data=0x00611113 with ack after 3 wait cycles → imem_read high for exactly 4 cycles with imem_address=4, funct3=001, imm12=0x006, instr_pc=4.
- S-type and U-type immediates:
  - 0x00512423 → op=0100011, rs1=2, rs2=5, imm12=0x008, immhi=0.
  - 0x123450B7 → op=0110111, rd=1, immhi=0x12345, imm12=0.
- Misaligned PC: PCin=0x6 with IRenable → imem_read never asserts, decodeComplete=1, fetch_fault=1, illegal=1, op=0.
- Reset and timeout:
  - Reset asserted in FETCH → imem_read=0 and decodeComplete=0 after the reset edge; a late ack causes no state change.
  - With FETCH_TIMEOUT_EN and FETCH_TIMEOUT=4, no ack → fetch_fault=1 and decodeComplete=1 after 4 FETCH cycles.

Source files
------------

// File: rtl/instr_fetch_decode_if.sv
`default_nettype none
// ==========================================================================
// instr_fetch_decode_if : controller strobe/PC, imem read/ack bus and decoded fields
// Rev 1.0
// ==========================================================================
interface instr_fetch_decode_if;
  logic        IRenable;
  logic [31:0] PCin;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [11:0] imm12;
  logic [19:0] immhi;
  logic [31:0] instr_pc;
  logic        decodeComplete;
  logic        illegal;
  logic        fetch_fault;

  modport master (
    input  IRenable, PCin, imem_data, imem_ack,
    output imem_read, imem_address, op, funct3, funct7, rs1, rs2, rd,
           imm12, immhi, instr_pc, decodeComplete, illegal, fetch_fault
  );

  modport slave (
    output IRenable, PCin, imem_data, imem_ack,
    input  imem_read, imem_address, op, funct3, funct7, rs1, rs2, rd,
           imm12, immhi, instr_pc, decodeComplete, illegal, fetch_fault
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ==========================================================================
// instr_fetch_decode : fetches one word on IRenable and splits it into RV32I
// fields. Optional macro FETCH_TIMEOUT_EN adds an imem_ack wait timeout. Rev 1.0
// ==========================================================================
module instr_fetch_decode #(
  parameter int XLEN          = 32,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_decode_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [6:0]  op_q, op_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] imm12_q, imm12_d;
  logic [19:0] immhi_q, immhi_d;
  logic        decode_complete_q, decode_complete_d;
  logic        illegal_q, illegal_d;
  logic        fetch_fault_q, fetch_fault_d;

  logic [11:0] imm12_w;
  logic [19:0] immhi_w;
  logic        illegal_w;
  logic        timeout_w;

  // The datapath is hard-wired to 32 bits and the wait counter to 8 bits.
  always_ff @(posedge clk) begin
    assert (XLEN == 32 && FETCH_TIMEOUT >= 1 && FETCH_TIMEOUT <= 255);
  end

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q != FETCH) begin
      wait_cnt_d = 8'd0;
    end else if (!bus.imem_ack) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Fires on the FETCH cycle whose increment would make the count reach the limit.
  assign timeout_w = (state_q == FETCH) && !bus.imem_ack &&
                     (({1'b0, wait_cnt_q} + 9'd1) == 9'(FETCH_TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_w = 1'b0;
`endif

  always_comb begin
    imm12_w   = 12'd0;
    immhi_w   = 20'd0;
    illegal_w = 1'b0;
    case (ir_q[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm12_w = ir_q[31:20];
      OP_STORE:  imm12_w = {ir_q[31:25], ir_q[11:7]};
      OP_BRANCH: imm12_w = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8]};
      OP_LUI, OP_AUIPC: immhi_w = ir_q[31:12];
      OP_JAL:    immhi_w = {ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21]};
      OP_REG, OP_FENCE: ;
      default:   illegal_w = 1'b1;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    ir_d              = ir_q;
    instr_pc_d        = instr_pc_q;
    op_d              = op_q;
    funct3_d          = funct3_q;
    funct7_d          = funct7_q;
    rs1_d             = rs1_q;
    rs2_d             = rs2_q;
    rd_d              = rd_q;
    imm12_d           = imm12_q;
    immhi_d           = immhi_q;
    decode_complete_d = decode_complete_q;
    illegal_d         = illegal_q;
    fetch_fault_d     = fetch_fault_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.IRenable) begin
          pc_d              = bus.PCin;
          decode_complete_d = 1'b0;
          illegal_d         = 1'b0;
          fetch_fault_d     = 1'b0;
          if (bus.PCin[1:0] == 2'b00) begin
            state_d = FETCH;
          end else begin
            // Misaligned: skip the memory and decode an all-zero word.
            ir_d          = 32'd0;
            fetch_fault_d = 1'b1;
            state_d       = DECODE;
          end
        end
      end
      FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          state_d = DECODE;
        end else if (timeout_w) begin
          ir_d          = 32'd0;
          fetch_fault_d = 1'b1;
          state_d       = DECODE;
        end
      end
      DECODE: begin
        op_d              = ir_q[6:0];
        funct3_d          = ir_q[14:12];
        funct7_d          = ir_q[31:25];
        rs1_d             = ir_q[19:15];
        rs2_d             = ir_q[24:20];
        rd_d              = ir_q[11:7];
        imm12_d           = imm12_w;
        immhi_d           = immhi_w;
        illegal_d         = illegal_w;
        instr_pc_d        = pc_q;
        decode_complete_d = 1'b1;
        state_d           = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      pc_q              <= 32'd0;
      ir_q              <= 32'd0;
      instr_pc_q        <= 32'd0;
      op_q              <= 7'd0;
      funct3_q          <= 3'd0;
      funct7_q          <= 7'd0;
      rs1_q             <= 5'd0;
      rs2_q             <= 5'd0;
      rd_q              <= 5'd0;
      imm12_q           <= 12'd0;
      immhi_q           <= 20'd0;
      decode_complete_q <= 1'b0;
      illegal_q         <= 1'b0;
      fetch_fault_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      ir_q              <= ir_d;
      instr_pc_q        <= instr_pc_d;
      op_q              <= op_d;
      funct3_q          <= funct3_d;
      funct7_q          <= funct7_d;
      rs1_q             <= rs1_d;
      rs2_q             <= rs2_d;
      rd_q              <= rd_d;
      imm12_q           <= imm12_d;
      immhi_q           <= immhi_d;
      decode_complete_q <= decode_complete_d;
      illegal_q         <= illegal_d;
      fetch_fault_q     <= fetch_fault_d;
    end
  end

  assign bus.imem_read      = (state_q == FETCH);
  assign bus.imem_address   = (state_q == FETCH) ? pc_q : 32'd0;
  assign bus.op             = op_q;
  assign bus.funct3         = funct3_q;
  assign bus.funct7         = funct7_q;
  assign bus.rs1            = rs1_q;
  assign bus.rs2            = rs2_q;
  assign bus.rd             = rd_q;
  assign bus.imm12          = imm12_q;
  assign bus.immhi          = immhi_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.decodeComplete = decode_complete_q;
  assign bus.illegal        = illegal_q;
  assign bus.fetch_fault    = fetch_fault_q;

endmodule
`default_nettype wire
